// File: rtl/huff_pkg.sv
// huff_pkg: shared definitions for the streaming Huffman packer.
//   DEF_SYM_W / DEF_MAX_LEN / DEF_LEN_W : default symbol, code and length widths
//   state_t      : packer state (RUN = packing, FLUSH = draining the final bits)
//   huff_entry_t : code-table entry layout at the default widths
//   nbits_w()    : width needed to express 0..out_w meaningful bits
package huff_pkg;

  localparam int DEF_SYM_W   = 4;
  localparam int DEF_MAX_LEN = 15;
  localparam int DEF_LEN_W   = 4;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [DEF_MAX_LEN-1:0] code;
    logic [DEF_LEN_W-1:0]   len;
  } huff_entry_t;

  function automatic int nbits_w(input int out_w);
    return $clog2(out_w + 1);
  endfunction

endpackage

// File: rtl/huff_code_table.sv
// huff_code_table: 2**SYM_W entry code table, synchronous write, combinational read.
//   CLK, RST      : clock, synchronous active-high reset (clears every entry, len=0)
//   we/waddr      : write strobe and symbol address
//   wcode/wlen    : right-aligned code and its length (0 = symbol invalid)
//   raddr         : lookup symbol
//   rcode/rlen    : looked-up code and length
module huff_code_table
  import huff_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               we,
  input  logic [SYM_W-1:0]   waddr,
  input  logic [MAX_LEN-1:0] wcode,
  input  logic [LEN_W-1:0]   wlen,
  input  logic [SYM_W-1:0]   raddr,
  output logic [MAX_LEN-1:0] rcode,
  output logic [LEN_W-1:0]   rlen
);

  localparam int unsigned DEPTH = 2 ** SYM_W;

  // Same layout as huff_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
  } entry_t;

  entry_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i[SYM_W-1:0]] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= '{code: wcode, len: wlen};
    end
  end

  assign rcode = mem[raddr].code;
  assign rlen  = mem[raddr].len;

endmodule

// File: rtl/huff_stream_packer.sv
// huff_stream_packer: looks symbols up in a loadable code table and packs the
// variable-length codes MSB-first into OUT_W-bit words.
//   CLK, RST                      : clock, synchronous active-high reset
//   tbl_we/tbl_addr/tbl_code/tbl_len : code-table write port (ignored while busy)
//   in_valid/in_ready/in_sym/in_last : symbol stream in
//   out_valid/out_ready/out_data/out_last/out_nbits : packed word stream out
//   err                           : sticky error (invalid symbol or rejected table write)
//   busy                          : a stream with at least one coded symbol is open
//   bit_count                     : code bits accepted in the current stream
//                                   (only when HUFF_BITCOUNT_EN is defined)
module huff_stream_packer
  import huff_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int OUT_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        tbl_we,
  input  logic [SYM_W-1:0]            tbl_addr,
  input  logic [MAX_LEN-1:0]          tbl_code,
  input  logic [LEN_W-1:0]            tbl_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SYM_W-1:0]            in_sym,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic                        out_last,
  output logic [nbits_w(OUT_W)-1:0]   out_nbits,
`ifdef HUFF_BITCOUNT_EN
  output logic [CNT_W-1:0]            bit_count,
`endif
  output logic                        err,
  output logic                        busy
);

  localparam int ACC_W  = OUT_W + MAX_LEN;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int NB_W   = nbits_w(OUT_W);
  localparam logic [FILL_W-1:0] FILL_OUT = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] FILL_ACC = FILL_W'(ACC_W);

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [FILL_W-1:0]   fill;

  logic [MAX_LEN-1:0]  rd_code;
  logic [LEN_W-1:0]    rd_len;
  logic [MAX_LEN-1:0]  code_mask;
  logic [FILL_W-1:0]   shamt;
  logic [ACC_W-1:0]    appended;
  logic                accept;
  logic                pop;
  logic                final_word;
  logic                tbl_wr_ok;

  assign tbl_wr_ok = !busy && (int'(tbl_len) <= MAX_LEN);

  huff_code_table #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_table (
    .CLK   (CLK),
    .RST   (RST),
    .we    (tbl_we && tbl_wr_ok),
    .waddr (tbl_addr),
    .wcode (tbl_code),
    .wlen  (tbl_len),
    .raddr (in_sym),
    .rcode (rd_code),
    .rlen  (rd_len)
  );

  // Handshake and output view are decoded from registered state only.
  assign in_ready   = (state == RUN) && (fill < FILL_OUT);
  assign accept     = in_valid && in_ready;
  assign final_word = (state == FLUSH) && (fill <= FILL_OUT);
  assign out_valid  = (state == FLUSH) || (fill >= FILL_OUT);
  assign out_data   = acc[ACC_W-1 -: OUT_W];
  assign out_last   = final_word;
  assign pop        = out_valid && out_ready;

  always_comb begin
    out_nbits = '0;
    if (final_word) begin
      out_nbits = NB_W'(fill);
    end else if (out_valid) begin
      out_nbits = NB_W'(OUT_W);
    end
  end

  // Bits above the code length are masked so the code lands directly below
  // the existing left-aligned bits without disturbing them.
  assign code_mask = ~({MAX_LEN{1'b1}} << rd_len);
  assign shamt     = FILL_ACC - fill - FILL_W'(rd_len);
  assign appended  = {{OUT_W{1'b0}}, rd_code & code_mask} << shamt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      acc   <= '0;
      fill  <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (tbl_we && !tbl_wr_ok) begin
        err <= 1'b1;
      end
      if (accept) begin
        if (rd_len == '0) begin
          err <= 1'b1;
        end else begin
          acc  <= acc | appended;
          fill <= fill + FILL_W'(rd_len);
          busy <= 1'b1;
        end
        if (in_last) begin
          state <= FLUSH;
        end
      end else if (pop) begin
        if (final_word) begin
          state <= RUN;
          acc   <= '0;
          fill  <= '0;
          busy  <= 1'b0;
        end else begin
          acc  <= acc << OUT_W;
          fill <= fill - FILL_OUT;
        end
      end
    end
  end

`ifdef HUFF_BITCOUNT_EN
  // busy is low exactly between streams, so the first accept of a stream
  // restarts the count while the previous total stays visible until then.
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W:0]   cnt_sum;

  always_comb begin
    cnt_base = busy ? bit_count : '0;
    cnt_sum  = {1'b0, cnt_base} + (CNT_W+1)'(rd_len);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_count <= '0;
    end else if (accept) begin
      bit_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_huff_stream_packer.sv
// tb_huff_stream_packer: directed scenarios plus randomized streams, checked
// against a bit-queue model of the packing rules.
module tb_huff_stream_packer;

  localparam int SYM_W   = 4;
  localparam int MAX_LEN = 3;
  localparam int LEN_W   = 2;
  localparam int OUT_W   = 8;
  localparam int CNT_W   = 16;
  localparam int NB_W    = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               tbl_we = 1'b0;
  logic [SYM_W-1:0]   tbl_addr = '0;
  logic [MAX_LEN-1:0] tbl_code = '0;
  logic [LEN_W-1:0]   tbl_len = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [SYM_W-1:0]   in_sym = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_last;
  logic [NB_W-1:0]    out_nbits;
  logic               err;
  logic               busy;
`ifdef HUFF_BITCOUNT_EN
  logic [CNT_W-1:0]   bit_count;
`endif

  huff_stream_packer #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .OUT_W   (OUT_W),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_code  (tbl_code),
    .tbl_len   (tbl_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_nbits (out_nbits),
`ifdef HUFF_BITCOUNT_EN
    .bit_count (bit_count),
`endif
    .err       (err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         nb;
  } word_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t got[$];
  word_t exp_w[$];

  // reference model state
  bit    mq[$];
  int    mcode[16];
  int    mlen[16];
  bit    merr  = 1'b0;
  bit    mopen = 1'b0;
  int    mcnt  = 0;

  int    stall_req  = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void emit(input bit last);
    word_t w;
    int    n;
    w.data = '0;
    n = (mq.size() < 8) ? mq.size() : 8;
    for (int i = 0; i < n; i++) w.data[7-i] = mq.pop_front();
    w.last = last;
    w.nb   = n;
    exp_w.push_back(w);
  endfunction

  // Full words leave while the stream is open; after the last symbol the
  // remainder (possibly empty) goes out as one final word.
  function automatic void model_push(input int sym, input bit last);
    int len;
    len = mlen[sym];
    if (len == 0) begin
      merr = 1'b1;
    end else begin
      for (int b = len - 1; b >= 0; b--) mq.push_back(((mcode[sym] >> b) & 1) != 0);
      mopen = 1'b1;
      mcnt  = (mcnt + len > 65535) ? 65535 : mcnt + len;
    end
    if (!last) begin
      while (mq.size() >= 8) emit(1'b0);
    end else begin
      while (mq.size() > 8) emit(1'b0);
      emit(1'b1);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      mcode[i] = 0;
      mlen[i]  = 0;
    end
    merr  = 1'b0;
    mopen = 1'b0;
    mcnt  = 0;
    mq.delete();
    exp_w.delete();
  endfunction

  // ---------------- sink side ----------------
  initial begin
    int seen;
    int left;
    seen = 0;
    left = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge CLK); #1;
      if (stall_req != seen && out_valid) begin
        seen = stall_req;
        left = 3;
      end
      if (left > 0) begin
        out_ready = 1'b0;
        left--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    bit    hold;
    word_t pw;
    word_t w;
    hold = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(pw.data));
          check("hold_last", 32'(out_last), 32'(pw.last));
          check("hold_nbits", 32'(out_nbits), 32'(pw.nb));
        end
        if (out_valid && !out_ready) check("in_ready_while_out_pending", 32'(in_ready), 32'd0);
        w.data = out_data;
        w.last = out_last;
        w.nb   = int'(out_nbits);
        if (out_valid && out_ready) got.push_back(w);
        hold = out_valid && !out_ready;
        pw   = w;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    RST      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    tbl_we   = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_clear();
    got.delete();
  endtask

  task automatic write_tbl(input int a, input int c, input int l);
    tbl_we   = 1'b1;
    tbl_addr = SYM_W'(a);
    tbl_code = MAX_LEN'(c);
    tbl_len  = LEN_W'(l);
    @(posedge CLK);
    if (mopen) merr = 1'b1;
    else begin
      mcode[a] = c;
      mlen[a]  = l;
    end
    #1;
    tbl_we = 1'b0;
  endtask

  task automatic load_std();
    write_tbl(1, 3'b011, 2);
    write_tbl(2, 3'b010, 2);
    write_tbl(3, 3'b001, 2);
    write_tbl(4, 3'b001, 3);
    write_tbl(5, 3'b000, 3);
  endtask

  task automatic push_sym(input int sym, input bit last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_sym   = SYM_W'(sym);
    in_last  = last;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge CLK);
      if (in_ready) begin
        @(posedge CLK); #1;
        ok = 1'b1;
        model_push(sym, last);
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_stream(input int syms[$], input bit rnd, input bit stall, input int wr_after);
    int n;
    mcnt = 0;
    got.delete();
    exp_w.delete();
    rand_ready = rnd;
    if (stall) stall_req++;
    foreach (syms[i]) begin
      push_sym(syms[i], i == syms.size() - 1);
      if (i == wr_after) begin
        check("busy_mid_stream", 32'(busy), 32'(mopen));
        write_tbl(1, 3'b001, 2);
        check("err_after_write", 32'(err), 32'(merr));
      end
    end
    for (int c = 0; c < 500 && got.size() < exp_w.size(); c++) @(posedge CLK);
    repeat (2) @(posedge CLK);
    #1;
    check("word_count", 32'(got.size()), 32'(exp_w.size()));
    n = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      check("word_data", 32'(got[i].data), 32'(exp_w[i].data));
      check("word_last", 32'(got[i].last), 32'(exp_w[i].last));
      check("word_nbits", 32'(got[i].nb), 32'(exp_w[i].nb));
    end
    check("busy_after", 32'(busy), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("out_valid_after", 32'(out_valid), 32'd0);
    check("err_after", 32'(err), 32'(merr));
`ifdef HUFF_BITCOUNT_EN
    check("bit_count", 32'(bit_count), 32'(mcnt));
`endif
    mopen      = 1'b0;
    rand_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s[$];
    int len;

    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_nbits", 32'(out_nbits), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    load_std();
    s = {1, 2, 3, 4, 5};
    run_stream(s, 1'b0, 1'b0, -1);          // 0xE4, then 0x80 / 4 bits
    s = {1, 2, 3, 1};
    run_stream(s, 1'b0, 1'b0, -1);          // single full final word 0xE7
    s = {1, 2, 3, 4, 5};
    run_stream(s, 1'b0, 1'b1, -1);          // 3-cycle stall on the first word

    s = {1, 2, 1, 3};
    run_stream(s, 1'b0, 1'b0, 1);           // write while busy is rejected

    // reset in the middle of a stream
    push_sym(1, 1'b0);
    push_sym(2, 1'b0);
    do_reset();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    s = {1};
    run_stream(s, 1'b0, 1'b0, -1);          // table empty: err, empty final word

    do_reset();
    load_std();
    s = {7};
    run_stream(s, 1'b0, 1'b0, -1);          // unloaded symbol alone

    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_reset();
        for (int a = 0; a < 8; a++) write_tbl(a, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end
      s.delete();
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) s.push_back(int'($urandom_range(0, 7)));
      run_stream(s, 1'b1, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0) ? 0 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
